// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the sequential divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   localparam int MAX_W = 64;

   typedef logic [MAX_W-1:0] word_t;

   localparam word_t DIV0_QUOTIENT = '1;

   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction

   // Magnitude of a w-bit value held in the low bits of a word_t.
   function automatic word_t abs_val(
      input word_t v,
      input int    w,
      input logic  is_signed
   );
      word_t mask;
      word_t sbit;
      mask = (word_t'(1) << w) - word_t'(1);
      sbit = word_t'(1) << (w - 1);
      if (is_signed && ((v & sbit) != '0))
         return (~v + word_t'(1)) & mask;
      return v & mask;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor, emit one quotient bit.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_p,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_p,
   output logic [WIDTH-1:0] o_a
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_trial;
   logic           w_neg;

   // The working remainder is WIDTH+1 bits; the stored one always
   // fits in WIDTH bits since it stays below the divisor.
   assign w_shift = {i_p, i_a[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, i_b};
   assign w_neg   = w_trial[WIDTH];

   assign o_p = w_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
   assign o_a = {i_a[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider (DIV/DIVU/REM unit), one quotient
// bit per clock; quotient to LO, remainder to HI.
module div_seq
   import div_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] HI
);

   localparam int CNT_W = cnt_w(WIDTH);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_p;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_zero;

   logic             w_sgn;
   logic             w_sa;
   logic             w_sb;
   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH-1:0] w_p_nxt;
   logic [WIDTH-1:0] w_a_nxt;

   assign w_sgn   = SIGNED_EN & is_signed;
   assign w_sa    = w_sgn & A[WIDTH-1];
   assign w_sb    = w_sgn & B[WIDTH-1];
   assign w_abs_a = WIDTH'(abs_val(word_t'(A), WIDTH, w_sgn));
   assign w_abs_b = WIDTH'(abs_val(word_t'(B), WIDTH, w_sgn));

   div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .i_p(r_p),
      .i_a(r_a),
      .i_b(r_b),
      .o_p(w_p_nxt),
      .o_a(w_a_nxt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_p         <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_qneg      <= 1'b0;
         r_rneg      <= 1'b0;
         r_zero      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         LO          <= '0;
         HI          <= '0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  r_qneg      <= w_sa ^ w_sb;
                  r_rneg      <= w_sa;
                  r_p         <= '0;
                  r_cnt       <= '0;
                  r_b         <= w_abs_b;
                  r_zero      <= (B == '0);
                  // Zero divisor keeps the raw dividend for HI.
                  if (B == '0) begin
                     r_a     <= A;
                     r_state <= FIX;
                  end else begin
                     r_a     <= w_abs_a;
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               r_p   <= w_p_nxt;
               r_a   <= w_a_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == CNT_W'(WIDTH - 1))
                  r_state <= FIX;
            end
            FIX: begin
               if (r_zero) begin
                  LO          <= DIV0_QUOTIENT[WIDTH-1:0];
                  HI          <= r_a;
                  div_by_zero <= 1'b1;
               end else begin
                  LO <= r_qneg ? -r_a : r_a;
                  HI <= r_rneg ? -r_p : r_p;
               end
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a 32-bit signed instance and an 8-bit
// unsigned-only instance, checked against an arithmetic model.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        st0, sg0, st1, sg1;
   logic [31:0] a0, b0, lo0, hi0;
   logic [7:0]  a1, b1, lo1, hi1;
   logic        busy0, done0, dz0;
   logic        busy1, done1, dz1;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   bit chk_en = 0;

   longint unsigned m_lo[2], m_hi[2], m_q[2], m_r[2];
   bit              m_z[2], m_qz[2], m_pend[2];
   int              m_acc[2], m_lat[2];

   div_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) dut0 (
      .clk(clk), .reset(reset), .start(st0), .is_signed(sg0),
      .A(a0), .B(b0), .busy(busy0), .done(done0),
      .div_by_zero(dz0), .LO(lo0), .HI(hi0)
   );

   div_seq #(.WIDTH(8), .SIGNED_EN(1'b0)) dut1 (
      .clk(clk), .reset(reset), .start(st1), .is_signed(sg1),
      .A(a1), .B(b1), .busy(busy1), .done(done1),
      .div_by_zero(dz1), .LO(lo1), .HI(hi1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Quotient truncates toward zero, remainder follows the dividend.
   function automatic void model(
      input longint unsigned a, input longint unsigned b,
      input bit sgn, input int w,
      output longint unsigned q, output longint unsigned r,
      output bit z);
      longint unsigned m;
      longint sa, sb;
      m = (64'd1 << w) - 64'd1;
      z = (b == 0);
      q = 0;
      r = 0;
      if (z) begin
         q = m;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else begin
         sa = $signed(a);
         sb = $signed(b);
         if (a[w-1]) sa = sa - $signed(64'd1 << w);
         if (b[w-1]) sb = sb - $signed(64'd1 << w);
         q = $unsigned(sa / sb) & m;
         r = $unsigned(sa % sb) & m;
      end
   endfunction

   task automatic m_accept(input int i, input longint unsigned a,
                           input longint unsigned b, input bit sgn);
      int w;
      w = (i == 0) ? 32 : 8;
      model(a, b, (i == 0) ? sgn : 1'b0, w, m_q[i], m_r[i], m_qz[i]);
      m_lat[i]  = m_qz[i] ? 1 : w + 1;
      m_acc[i]  = cyc;
      m_pend[i] = 1;
      m_z[i]    = 0;
   endtask

   task automatic m_reset();
      for (int i = 0; i < 2; i++) begin
         m_lo[i] = 0; m_hi[i] = 0; m_z[i] = 0; m_pend[i] = 0;
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            logic [63:0] alo, ahi;
            logic        ad, ab, az;
            bit          ed;
            if (i == 0) begin
               alo = {32'b0, lo0}; ahi = {32'b0, hi0};
               ad = done0; ab = busy0; az = dz0;
            end else begin
               alo = {56'b0, lo1}; ahi = {56'b0, hi1};
               ad = done1; ab = busy1; az = dz1;
            end
            ed = m_pend[i] && (cyc == m_acc[i] + m_lat[i]);
            if (ed) begin
               m_lo[i]   = m_q[i];
               m_hi[i]   = m_r[i];
               m_z[i]    = m_qz[i];
               m_pend[i] = 0;
            end
            chk($sformatf("m%0d_done@%0d", i, cyc), {63'b0, ad}, {63'b0, ed});
            chk($sformatf("m%0d_busy@%0d", i, cyc), {63'b0, ab},
                {63'b0, m_pend[i]});
            chk($sformatf("m%0d_lo@%0d", i, cyc), alo, m_lo[i]);
            chk($sformatf("m%0d_hi@%0d", i, cyc), ahi, m_hi[i]);
            chk($sformatf("m%0d_dz@%0d", i, cyc), {63'b0, az},
                {63'b0, m_z[i]});
         end
      end
   end

   // Caller sits just after a negedge; returns at the done negedge.
   task automatic run_op(input int i, input longint unsigned a,
                         input longint unsigned b, input bit sgn,
                         input longint unsigned eq, input longint unsigned er,
                         input bit ez, input int elat, input int poke);
      int acc, n;
      bit dn;
      if (i == 0) begin
         st0 = 1; sg0 = sgn; a0 = a[31:0]; b0 = b[31:0];
      end else begin
         st1 = 1; sg1 = sgn; a1 = a[7:0]; b1 = b[7:0];
      end
      @(posedge clk);
      #1;
      acc = cyc;
      m_accept(i, a, b, sgn);
      st0 = 0;
      st1 = 0;
      n = 0;
      dn = 0;
      while (!dn && n < 100) begin
         @(negedge clk);
         n++;
         if (i == 0 && n == poke) begin
            st0 = 1; sg0 = 0; a0 = 32'd77; b0 = 32'd5;
         end else begin
            st0 = 0;
         end
         dn = (i == 0) ? done0 : done1;
      end
      chk($sformatf("lat_%0h_%0h", a, b), 64'(cyc - acc), 64'(elat));
      if (i == 0) begin
         chk($sformatf("lo_%0h_%0h", a, b), {32'b0, lo0}, eq);
         chk($sformatf("hi_%0h_%0h", a, b), {32'b0, hi0}, er);
         chk($sformatf("dz_%0h_%0h", a, b), {63'b0, dz0}, {63'b0, ez});
      end else begin
         chk($sformatf("lo8_%0h_%0h", a, b), {56'b0, lo1}, eq);
         chk($sformatf("hi8_%0h_%0h", a, b), {56'b0, hi1}, er);
         chk($sformatf("dz8_%0h_%0h", a, b), {63'b0, dz1}, {63'b0, ez});
      end
   endtask

   initial begin
      longint unsigned q, r;
      bit z;
      int seen;

      model(100, 7, 0, 32, q, r, z);
      chk("pin_u_q", q, 14);
      chk("pin_u_r", r, 2);
      model(64'hFFFFFF9C, 7, 1, 32, q, r, z);
      chk("pin_s_q", q, 64'hFFFFFFF2);
      chk("pin_s_r", r, 64'hFFFFFFFE);
      model(64'h80000000, 64'hFFFFFFFF, 1, 32, q, r, z);
      chk("pin_ovf_q", q, 64'h80000000);
      chk("pin_ovf_r", r, 0);
      model(200, 3, 0, 8, q, r, z);
      chk("pin_8_q", q, 66);
      chk("pin_8_r", r, 2);

      reset = 1;
      st0 = 0; sg0 = 0; a0 = 0; b0 = 0;
      st1 = 0; sg1 = 0; a1 = 0; b1 = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1;
      chk("rst_lo", {32'b0, lo0}, 0);
      chk("rst_hi", {32'b0, hi0}, 0);
      chk("rst_busy", {63'b0, busy0}, 0);
      chk("rst_done", {63'b0, done0}, 0);
      @(negedge clk);
      reset = 0;

      run_op(0, 100, 7, 0, 14, 2, 0, 33, 0);
      @(negedge clk);
      run_op(0, 64'hFFFFFF9C, 7, 1, 64'hFFFFFFF2, 64'hFFFFFFFE, 0, 33, 0);
      @(negedge clk);
      run_op(0, 100, 64'hFFFFFFF9, 1, 64'hFFFFFFF2, 2, 0, 33, 0);
      @(negedge clk);
      run_op(0, 5, 0, 0, 64'hFFFFFFFF, 5, 1, 1, 0);
      @(negedge clk);
      run_op(0, 9, 3, 0, 3, 0, 0, 33, 0);
      run_op(0, 64'h80000000, 64'hFFFFFFFF, 1, 64'h80000000, 0, 0, 33, 0);
      run_op(0, 64'h80000000, 64'hFFFFFFFF, 0, 0, 64'h80000000, 0, 33, 0);
      run_op(0, 64'hFFFFFFF9, 0, 1, 64'hFFFFFFFF, 64'hFFFFFFF9, 1, 1, 0);
      run_op(0, 64'hFFFFFFF9, 2, 1, 64'hFFFFFFFD, 64'hFFFFFFFF, 0, 33, 0);
      run_op(0, 7, 64'hFFFFFFFE, 1, 64'hFFFFFFFD, 1, 0, 33, 0);
      run_op(0, 64'hFFFFFFFF, 1, 0, 64'hFFFFFFFF, 0, 0, 33, 0);
      @(negedge clk);
      run_op(0, 1000, 10, 0, 100, 0, 0, 33, 10);

      @(negedge clk);
      st0 = 1; sg0 = 0; a0 = 32'd123; b0 = 32'd4;
      @(posedge clk);
      #1;
      m_accept(0, 123, 4, 0);
      st0 = 0;
      repeat (15) @(negedge clk);
      reset = 1;
      @(posedge clk);
      #1;
      m_reset();
      @(negedge clk);
      reset = 0;
      chk("mid_rst_lo", {32'b0, lo0}, 0);
      chk("mid_rst_hi", {32'b0, hi0}, 0);
      chk("mid_rst_busy", {63'b0, busy0}, 0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done0) seen++;
      end
      chk("no_done_after_rst", 64'(seen), 0);

      run_op(1, 200, 3, 1, 66, 2, 0, 9, 0);
      run_op(1, 250, 7, 0, 35, 5, 0, 9, 0);
      run_op(1, 17, 0, 0, 64'hFF, 17, 1, 1, 0);
      @(negedge clk);
      run_op(1, 255, 1, 1, 255, 0, 0, 9, 0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
